// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared defaults and encodings for the two-port RAM arbiter.
// The optional burst-lock feature is selected with the RAM_ARB_LOCK_EN macro.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 10;

  // Requester indices: the core has index 0, the loader/debug master index 1.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  // One-hot acknowledge vector for a requester index.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin winner selection.
// With RAM_ARB_LOCK_EN defined, a locked previous owner that still requests keeps
// the RAM; otherwise lock and prev_owner are ignored.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       prev_owner,
  input  logic [1:0] lock,
  output logic       valid,
  output logic       winner
);

`ifdef RAM_ARB_LOCK_EN
  // Sole requester wins, contention goes to rr_ptr, a held lock overrides both.
  always_comb begin
    valid  = |req;
    winner = rr_ptr;
    if (req == 2'b01) begin
      winner = REQ_CORE;
    end else if (req == 2'b10) begin
      winner = REQ_LOAD;
    end
    if (lock[prev_owner] && req[prev_owner]) begin
      winner = prev_owner;
    end
  end
`else
  // Sole requester wins, contention goes to rr_ptr.
  always_comb begin
    valid  = |req;
    winner = rr_ptr;
    if (req == 2'b01) begin
      winner = REQ_CORE;
    end else if (req == 2'b10) begin
      winner = REQ_LOAD;
    end
  end

  logic unused_lock;
  assign unused_lock = ^{lock, prev_owner};
`endif

endmodule

// File: rtl/ram_arbiter2.sv
// ram_arbiter2: round-robin arbiter and sequencer for the shared 1024x10 RAM.
// Each transaction walks IDLE -> ACCESS -> ACK; the RAM ports are driven only here.
// Optional macro RAM_ARB_LOCK_EN enables per-requester burst locking.
module ram_arbiter2
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          we_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   wdata0_i,
  input  logic [DATA_W-1:0]   wdata1_i,
  input  logic [1:0]          lock,
  output logic [1:0]          ack,
  output logic [2*DATA_W-1:0] rdata_o,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [2*DATA_W-1:0] ram_rdata
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]          ack_q, ack_d;

  logic pick_valid;
  logic pick_winner;

  rr_pick2 u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .prev_owner (owner_q),
    .lock       (lock),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Next-state logic: latch the winner's payload, run the access, then acknowledge.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rr_ptr_d = rr_ptr_q;
    rdata_d  = rdata_q;
    ack_d    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          we_d    = we_i[pick_winner];
          addr_d  = pick_winner ? addr1_i : addr0_i;
          wdata_d = pick_winner ? wdata1_i : wdata0_i;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The pair is captured on the same edge the write lands, so writes
        // return the contents as they were before the write.
        rdata_d = ram_rdata;
        ack_d   = owner_onehot(owner_q);
        state_d = ST_ACK;
      end
      ST_ACK: begin
`ifdef RAM_ARB_LOCK_EN
        if (!lock[owner_q]) begin
          rr_ptr_d = ~owner_q;
        end
`else
        rr_ptr_d = ~owner_q;
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= REQ_CORE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rr_ptr_q <= REQ_CORE;
      rdata_q  <= '0;
      ack_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rr_ptr_q <= rr_ptr_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
    end
  end

  // Write enable is gated by rst so no write can land on a reset edge.
  always_comb begin
    ram_we = (state_q == ST_ACCESS) && we_q && !rst;
  end

  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;
  assign rdata_o     = rdata_q;
  assign ack         = ack_q;

endmodule

// File: tb/tb_ram_arbiter2.sv
// tb_ram_arbiter2: directed bench for ram_arbiter2 with a behavioural RAM and a
// scoreboard of expected acknowledgements. Honors RAM_ARB_LOCK_EN when defined.
module tb_ram_arbiter2;
  import ram_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, we_i, lock;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [DW-1:0] wdata0_i, wdata1_i;
  logic [1:0]    ack;
  logic [2*DW-1:0] rdata_o;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_wdata;
  logic [2*DW-1:0] ram_rdata;

  logic          preload;
  logic [DW-1:0] mem    [0:1023];
  logic [DW-1:0] shadow [0:1023];

  typedef struct packed {
    logic          owner;
    logic          is_write;
    logic [2*DW-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   ack0_pulses = 0;
  int   we_cycles = 0;

  ram_arbiter2 dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we_i        (we_i),
    .addr0_i     (addr0_i),
    .addr1_i     (addr1_i),
    .wdata0_i    (wdata0_i),
    .wdata1_i    (wdata1_i),
    .lock        (lock),
    .ack         (ack),
    .rdata_o     (rdata_o),
    .ram_we      (ram_we),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    logic [31:0] t;
    if (i == 10) return 10'd5;
    if (i == 11) return 10'd3;
    t = i * 37 + 11;
    return t[DW-1:0];
  endfunction

  // Behavioural RAM: async even/odd pair read, synchronous write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_address] <= ram_wdata;
    end
  end

  assign ram_rdata = {mem[{ram_address[AW-1:1], 1'b1}], mem[{ram_address[AW-1:1], 1'b0}]};

  function automatic logic [2*DW-1:0] pair_of(input logic [AW-1:0] a);
    return {shadow[{a[AW-1:1], 1'b1}], shadow[{a[AW-1:1], 1'b0}]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [1:0] lk);
    req = r; we_i = w; addr0_i = a0; addr1_i = a1;
    wdata0_i = d0; wdata1_i = d1; lock = lk;
  endtask

  task automatic stepTo();
    @(posedge clk);
    #2;
  endtask

  // Push the expected completion; writes update the shadow after capturing the old pair.
  task automatic expectTxn(input logic owner, input logic is_write,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    exp_t e;
    e.owner    = owner;
    e.is_write = is_write;
    e.rdata    = pair_of(addr);
    sb_q.push_back(e);
    if (is_write) shadow[addr] = wdata;
  endtask

  task automatic waitAck(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < 12);
    if (ack == 2'b00) begin
      total++;
      bad++;
      $error("[TB] FAIL %s timeout ack=%b required=nonzero", tag, ack);
    end
  endtask

  task automatic runOne(input logic owner, input logic is_write,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input string tag);
    expectTxn(owner, is_write, addr, wdata);
    if (owner)
      applyStimulus(2'b10, {is_write, 1'b0}, 10'd0, addr, 10'd0, wdata, 2'b00);
    else
      applyStimulus(2'b01, {1'b0, is_write}, addr, 10'd0, wdata, 10'd0, 2'b00);
    waitAck(tag);
    stepTo();
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 2'b00);
  endtask

  // Monitor: pops the scoreboard on every acknowledge and checks owner, data, write pulses.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_cycles = 0;
      end else begin
        if (ram_we) we_cycles++;
        if (ack != 2'b00) begin
          checkOutput("ack_onehot", 32'($countones(ack)), 32'd1);
          if (ack[0]) ack0_pulses++;
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_ack", 32'(ack), 32'd0);
          end else begin
            e = sb_q.pop_front();
            checkOutput("ack_owner", 32'(ack), 32'(owner_onehot(e.owner)));
            checkOutput("ack_rdata", 32'(rdata_o), 32'(e.rdata));
            checkOutput("we_pulses", 32'(we_cycles), e.is_write ? 32'd1 : 32'd0);
          end
          we_cycles = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int snap;
    rst = 1'b1;
    preload = 1'b1;
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 2'b00);
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    repeat (3) stepTo();

    // Reset state
    @(negedge clk);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_rdata", 32'(rdata_o), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_ram_address", 32'(ram_address), 32'd0);
    checkOutput("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    stepTo();
    rst = 1'b0;
    preload = 1'b0;

    // Test 1: read addr 10, exact latency, then odd address and wrap address
    $display("[TB] test 1: core read");
    expectTxn(REQ_CORE, 1'b0, 10'd10, 10'd0);
    applyStimulus(2'b01, 2'b00, 10'd10, 10'd0, 10'd0, 10'd0, 2'b00);
    @(negedge clk);
    checkOutput("t1_idle_ack", 32'(ack), 32'd0);
    @(negedge clk);
    checkOutput("t1_access_ack", 32'(ack), 32'd0);
    @(negedge clk);
    checkOutput("t1_ack", 32'(ack), 32'd1);
    checkOutput("t1_pair", 32'(rdata_o), 32'h00C05);
    stepTo();
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 2'b00);
    runOne(REQ_CORE, 1'b0, 10'd11, 10'd0, "t1_odd");
    checkOutput("t1_odd_pair", 32'(rdata_o), 32'h00C05);
    runOne(REQ_CORE, 1'b0, 10'd1023, 10'd0, "t1_wrap");

    // Test 2: loader write, then core reads it back
    $display("[TB] test 2: loader write");
    runOne(REQ_LOAD, 1'b1, 10'd12, 10'h2A5, "t2_write");
    checkOutput("t2_mem", 32'(mem[12]), 32'h2A5);
    runOne(REQ_CORE, 1'b0, 10'd12, 10'd0, "t2_read");
    checkOutput("t2_rdata_lo", 32'(rdata_o[9:0]), 32'h2A5);

    // Test 3: both held; last owner was core so loader goes first, then alternate
    $display("[TB] test 3: contention");
    expectTxn(REQ_LOAD, 1'b0, 10'd31, 10'd0);
    expectTxn(REQ_CORE, 1'b0, 10'd20, 10'd0);
    expectTxn(REQ_LOAD, 1'b0, 10'd31, 10'd0);
    expectTxn(REQ_CORE, 1'b0, 10'd20, 10'd0);
    applyStimulus(2'b11, 2'b00, 10'd20, 10'd31, 10'd0, 10'd0, 2'b00);
    for (int k = 0; k < 4; k++) waitAck("t3_alt");
    stepTo();
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 2'b00);

    // Test 4: reset during the ACCESS cycle of a write to addr 50
    $display("[TB] test 4: reset mid-write");
    applyStimulus(2'b01, 2'b01, 10'd50, 10'd0, 10'h1C3, 10'd0, 2'b00);
    stepTo();
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 2'b00);
    @(negedge clk);
    checkOutput("t4_we_blocked", 32'(ram_we), 32'd0);
    stepTo();
    @(negedge clk);
    checkOutput("t4_ack", 32'(ack), 32'd0);
    checkOutput("t4_rdata", 32'(rdata_o), 32'd0);
    checkOutput("t4_ram_address", 32'(ram_address), 32'd0);
    checkOutput("t4_ram_wdata", 32'(ram_wdata), 32'd0);
    checkOutput("t4_mem50", 32'(mem[50]), 32'(shadow[50]));
    stepTo();
    rst = 1'b0;

    // Test 5: core holds lock with both requesting; lock dropped during third access
    $display("[TB] test 5: lock");
`ifdef RAM_ARB_LOCK_EN
    expectTxn(REQ_CORE, 1'b0, 10'd40, 10'd0);
    expectTxn(REQ_CORE, 1'b0, 10'd40, 10'd0);
    expectTxn(REQ_CORE, 1'b0, 10'd40, 10'd0);
    expectTxn(REQ_LOAD, 1'b0, 10'd61, 10'd0);
`else
    expectTxn(REQ_CORE, 1'b0, 10'd40, 10'd0);
    expectTxn(REQ_LOAD, 1'b0, 10'd61, 10'd0);
    expectTxn(REQ_CORE, 1'b0, 10'd40, 10'd0);
    expectTxn(REQ_LOAD, 1'b0, 10'd61, 10'd0);
`endif
    applyStimulus(2'b11, 2'b00, 10'd40, 10'd61, 10'd0, 10'd0, 2'b01);
    waitAck("t5_first");
    waitAck("t5_second");
    stepTo();
    stepTo();
    applyStimulus(2'b11, 2'b00, 10'd40, 10'd61, 10'd0, 10'd0, 2'b00);
    waitAck("t5_third");
    waitAck("t5_fourth");
    stepTo();
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 2'b00);

    // Test 6: core raises then drops req while the loader is being served
    $display("[TB] test 6: withdrawn request");
    snap = ack0_pulses;
    expectTxn(REQ_LOAD, 1'b0, 10'd100, 10'd0);
    expectTxn(REQ_LOAD, 1'b0, 10'd100, 10'd0);
    applyStimulus(2'b10, 2'b00, 10'd0, 10'd100, 10'd0, 10'd0, 2'b00);
    stepTo();
    applyStimulus(2'b11, 2'b01, 10'd200, 10'd100, 10'h0FF, 10'd0, 2'b00);
    stepTo();
    applyStimulus(2'b10, 2'b00, 10'd0, 10'd100, 10'd0, 10'd0, 2'b00);
    waitAck("t6_first");
    waitAck("t6_second");
    stepTo();
    applyStimulus(2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 2'b00);
    repeat (4) @(negedge clk);
    checkOutput("t6_no_ack0", 32'(ack0_pulses), 32'(snap));
    checkOutput("t6_mem200", 32'(mem[200]), 32'(shadow[200]));

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
